weight_biu: RTL

WEIGHT_BIU -- requirements
Module: weight_biu

---
 rtl/weight_biu.sv | 93 +++++++++
 1 files changed

// File: rtl/weight_biu.sv
// weight_biu: streams a block of 32-bit weight words from the bus arbiter into the weight buffer
module weight_biu #(
  parameter int BUF_AW  = 10,
  parameter int MAX_OUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [BUF_AW:0]   word_num,
  output logic              busy,
  output logic              done,
  output logic              weight_biu2arb_req,
  output logic [31:0]       weight_biu2arb_addr,
  output logic              weight_biu2arb_vld,
  input  logic              weight_biu2arb_rdy,
  input  logic [31:0]       arb2weight_biu_addr,
  input  logic [31:0]       arb2weight_biu_data,
  input  logic              arb2weight_biu_vld,
  output logic              arb2weight_biu_rdy,
  input  logic              wbuf_wr_rdy,
  output logic              wbuf_wen,
  output logic [BUF_AW-1:0] wbuf_waddr,
  output logic [31:0]       wbuf_wdata
);
  localparam int CW = BUF_AW + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0]   base;
  logic [CW-1:0] num, issued, returned;
  logic [OW-1:0] outstanding;
  logic          active, cmd_acc, rsp_acc;
  logic          unused_in;
  // response address is informational only; word order comes from the return count
  assign unused_in = ^{arb2weight_biu_addr, base_addr[1:0]};
  assign active = state == ISSUE || state == DRAIN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign weight_biu2arb_req = active;
  assign weight_biu2arb_vld = state == ISSUE && issued < num && outstanding < OUT_MAX;
  assign weight_biu2arb_addr = base + {30'(issued), 2'b00};
  assign arb2weight_biu_rdy = active && wbuf_wr_rdy && outstanding != '0;
  assign cmd_acc = weight_biu2arb_vld && weight_biu2arb_rdy;
  assign rsp_acc = arb2weight_biu_vld && arb2weight_biu_rdy;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: a zero-length load goes straight to the one-cycle done state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = word_num == '0 ? DONE : ISSUE;
      ISSUE:   if (cmd_acc && issued + CW'(1) == num) state_nxt = DRAIN;
      DRAIN:   if (returned == num) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // load parameters and issue/return/outstanding counters; simultaneous accepts cancel in outstanding
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base        <= '0;
      num         <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
    end else if (state == IDLE && start) begin
      base        <= {base_addr[31:2], 2'b00};
      num         <= word_num;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
    end else begin
      issued      <= issued + CW'(cmd_acc);
      returned    <= returned + CW'(rsp_acc);
      outstanding <= outstanding + OW'(cmd_acc) - OW'(rsp_acc);
    end
  // buffer write one cycle after each accepted response, indexed by arrival order
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wbuf_wen   <= 1'b0;
      wbuf_waddr <= '0;
      wbuf_wdata <= '0;
    end else begin
      wbuf_wen <= rsp_acc;
      if (rsp_acc) begin
        wbuf_waddr <= returned[BUF_AW-1:0];
        wbuf_wdata <= arb2weight_biu_data;
      end
    end
endmodule
